// File: rtl/gshare_predictor_if.sv
// rtl/gshare_predictor_if.sv - lookup/update/status bundle between the core pipeline and the gshare predictor
interface gshare_predictor_if #(
    parameter int IDX_W = 8,
    parameter int GH_W  = 8
);
    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic [GH_W-1:0]  pred_ghist;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_mispred;
    logic [GH_W-1:0]  upd_ghist;
    logic             init_busy;

    // core side: issues lookups and resolutions
    modport master (
        output pred_valid, pred_pc, upd_valid, upd_idx, upd_taken, upd_mispred, upd_ghist,
        input  pred_taken, pred_idx, pred_ghist, init_busy
    );

    // predictor side
    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_idx, upd_taken, upd_mispred, upd_ghist,
        output pred_taken, pred_idx, pred_ghist, init_busy
    );
endinterface

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor with speculative history and init sweep (optional BP_BYPASS_EN forwarding)
module gshare_predictor #(
    parameter int IDX_W    = 8,
    parameter int GH_W     = 8,
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    gshare_predictor_if.slave  bp
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX    = '1;
    localparam logic [CTR_W-1:0] CTR_INIT_V = CTR_W'(CTR_INIT);
    localparam logic [IDX_W-1:0] SWEEP_LAST = '1;

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_sweep;
    logic [GH_W-1:0]  r_spec_gh;
    logic             r_init_busy;
    logic [CTR_W-1:0] r_table [0:DEPTH-1];

    logic             w_ready;
    logic [IDX_W-1:0] w_gh_ext;
    logic [IDX_W-1:0] w_idx;
    logic [CTR_W-1:0] w_ctr_old;
    logic [CTR_W-1:0] w_ctr_next;
    logic [CTR_W-1:0] w_ctr_stored;
    logic             w_taken_raw;
    logic [GH_W-1:0]  w_gh_shift;
    logic [GH_W-1:0]  w_gh_restore;
    logic [31-IDX_W:0] w_unused_pc;

    assign w_ready     = (r_state == S_READY);
    assign w_unused_pc = {bp.pred_pc[31:IDX_W+2], bp.pred_pc[1:0]};

    // zero-extend the speculative history up to the index width
    always_comb begin
        w_gh_ext               = '0;
        w_gh_ext[GH_W-1:0]     = r_spec_gh;
    end

    assign w_idx        = bp.pred_pc[IDX_W+1:2] ^ w_gh_ext;
    assign w_ctr_stored = r_table[w_idx];

    // saturating counter step for the resolving branch
    always_comb begin
        w_ctr_old  = r_table[bp.upd_idx];
        w_ctr_next = w_ctr_old;
        if (bp.upd_taken) begin
            if (w_ctr_old != CTR_MAX) w_ctr_next = w_ctr_old + CTR_W'(1);
        end else begin
            if (w_ctr_old != '0) w_ctr_next = w_ctr_old - CTR_W'(1);
        end
    end

`ifdef BP_BYPASS_EN
    logic w_fwd;
    // a same-cycle update to the looked-up entry is forwarded to the prediction
    assign w_fwd       = w_ready && bp.upd_valid && (bp.upd_idx == w_idx);
    assign w_taken_raw = w_fwd ? w_ctr_next[CTR_W-1] : w_ctr_stored[CTR_W-1];
`else
    assign w_taken_raw = w_ctr_stored[CTR_W-1];
`endif

    // history shift on lookup and rebuild from the checkpoint on mispredict
    generate
        if (GH_W == 1) begin : g_gh1
            logic w_unused_gh;
            assign w_unused_gh  = bp.upd_ghist[0];
            assign w_gh_shift   = bp.pred_taken;
            assign w_gh_restore = bp.upd_taken;
        end else begin : g_ghn
            logic w_unused_gh;
            assign w_unused_gh  = bp.upd_ghist[GH_W-1];
            assign w_gh_shift   = {r_spec_gh[GH_W-2:0], bp.pred_taken};
            assign w_gh_restore = {bp.upd_ghist[GH_W-2:0], bp.upd_taken};
        end
    endgenerate

    assign bp.pred_taken = w_ready & w_taken_raw;
    assign bp.pred_idx   = w_idx;
    assign bp.pred_ghist = r_spec_gh;
    assign bp.init_busy  = r_init_busy;

    // INIT/READY control: sweep pointer, speculative history, busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_sweep     <= '0;
            r_spec_gh   <= '0;
            r_init_busy <= 1'b1;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_sweep <= r_sweep + IDX_W'(1);
                    if (r_sweep == SWEEP_LAST) begin
                        r_state     <= S_READY;
                        r_init_busy <= 1'b0;
                    end
                end
                S_READY: begin
                    // the lookup sharing a cycle with a mispredict is on the flushed path
                    if (bp.upd_valid && bp.upd_mispred) r_spec_gh <= w_gh_restore;
                    else if (bp.pred_valid)             r_spec_gh <= w_gh_shift;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    // counter storage: written only by the sweep or by resolved branches
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_INIT)  r_table[r_sweep]     <= CTR_INIT_V;
            else if (bp.upd_valid)  r_table[bp.upd_idx]  <= w_ctr_next;
        end
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - directed bench for gshare_predictor
module tb_gshare_predictor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    gshare_predictor_if #(.IDX_W(8), .GH_W(8)) bp ();

    gshare_predictor #(.IDX_W(8), .GH_W(8), .CTR_W(2), .CTR_INIT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bp.pred_valid  = 1'b0;
        bp.pred_pc     = 32'h0;
        bp.upd_valid   = 1'b0;
        bp.upd_idx     = 8'h0;
        bp.upd_taken   = 1'b0;
        bp.upd_mispred = 1'b0;
        bp.upd_ghist   = 8'h0;
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (bp.init_busy === 1'b1 && cycles < 1000) begin
            tick();
            cycles++;
        end
    endtask

    task automatic reset_and_init();
        int c;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_init(c);
        n_checks++;
        if (c != 256) begin
            n_fail++;
            $display("FAIL init_len got %0d expected 256", c);
        end
    endtask

    task automatic update(input logic [7:0] idx, input logic taken);
        bp.upd_valid = 1'b1;
        bp.upd_idx   = idx;
        bp.upd_taken = taken;
        tick();
        bp.upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        int c;
        idle_inputs();
        bp.pred_pc = 32'h0000_03FC;
        rst = 1'b1;
        tick();
        n_checks++;
        if (bp.init_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy got %b expected 1", bp.init_busy); end
        n_checks++;
        if (bp.pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken got %b expected 0", bp.pred_taken); end
        n_checks++;
        if (bp.pred_ghist !== 8'h00) begin n_fail++; $display("FAIL rst_ghist got %h expected 00", bp.pred_ghist); end
        n_checks++;
        if (bp.pred_idx !== 8'hFF) begin n_fail++; $display("FAIL rst_idx got %h expected ff", bp.pred_idx); end
        rst = 1'b0;
        wait_init(c);
        n_checks++;
        if (c != 256) begin n_fail++; $display("FAIL init_len got %0d expected 256", c); end
        for (int i = 0; i < 256; i++) begin
            bp.pred_pc = 32'(i) << 2;
            #1;
            n_checks++;
            if (bp.pred_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL init_entry idx %0d got %b expected 0", i, bp.pred_taken);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int c;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_init(c);
        n_checks++;
        if (c != 256) begin n_fail++; $display("FAIL restart_len got %0d expected 256", c); end
    endtask

    task automatic test_init_ignores();
        int c;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bp.pred_valid = 1'b1;
        bp.pred_pc    = 32'h14;
        bp.upd_valid  = 1'b1;
        bp.upd_idx    = 8'h05;
        bp.upd_taken  = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (bp.pred_taken !== 1'b0) begin n_fail++; $display("FAIL init_taken got %b expected 0", bp.pred_taken); end
        wait_init(c);
        idle_inputs();
        bp.pred_pc = 32'h14;
        #1;
        n_checks++;
        if (bp.pred_ghist !== 8'h00) begin n_fail++; $display("FAIL init_gh got %h expected 00", bp.pred_ghist); end
        n_checks++;
        if (bp.pred_taken !== 1'b0) begin n_fail++; $display("FAIL init_noupd got %b expected 0", bp.pred_taken); end
    endtask

    task automatic test_counter_saturation();
        logic exp_up [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic exp_dn [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        idle_inputs();
        reset_and_init();
        bp.pred_pc = 32'h14;
        #1;
        n_checks++;
        if (bp.pred_idx !== 8'h05) begin n_fail++; $display("FAIL sat_idx got %h expected 05", bp.pred_idx); end
        for (int i = 0; i < 4; i++) begin
            update(8'h05, 1'b1);
            n_checks++;
            if (bp.pred_taken !== exp_up[i]) begin
                n_fail++;
                $display("FAIL sat_up step %0d got %b expected %b", i, bp.pred_taken, exp_up[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            update(8'h05, 1'b0);
            n_checks++;
            if (bp.pred_taken !== exp_dn[i]) begin
                n_fail++;
                $display("FAIL sat_dn step %0d got %b expected %b", i, bp.pred_taken, exp_dn[i]);
            end
        end
        update(8'h05, 1'b1);
        n_checks++;
        if (bp.pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_floor got %b expected 0", bp.pred_taken); end
        update(8'h05, 1'b1);
        n_checks++;
        if (bp.pred_taken !== 1'b1) begin n_fail++; $display("FAIL sat_regain got %b expected 1", bp.pred_taken); end
    endtask

    task automatic test_spec_history();
        logic [31:0] pcs   [3] = '{32'h00, 32'h14, 32'h10};
        logic        exp_t [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0]  exp_g [3] = '{8'h00, 8'h00, 8'h01};
        idle_inputs();
        reset_and_init();
        update(8'h05, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bp.pred_valid = 1'b1;
            bp.pred_pc    = pcs[i];
            #1;
            n_checks++;
            if (bp.pred_taken !== exp_t[i]) begin
                n_fail++;
                $display("FAIL gh_taken step %0d got %b expected %b", i, bp.pred_taken, exp_t[i]);
            end
            n_checks++;
            if (bp.pred_ghist !== exp_g[i]) begin
                n_fail++;
                $display("FAIL gh_ckpt step %0d got %h expected %h", i, bp.pred_ghist, exp_g[i]);
            end
            tick();
        end
        bp.pred_valid = 1'b0;
        n_checks++;
        if (bp.pred_ghist !== 8'h03) begin n_fail++; $display("FAIL gh_final got %h expected 03", bp.pred_ghist); end
    endtask

    task automatic test_mispredict_restore();
        bp.pred_valid  = 1'b1;
        bp.pred_pc     = 32'h14;
        bp.upd_valid   = 1'b1;
        bp.upd_mispred = 1'b1;
        bp.upd_idx     = 8'h20;
        bp.upd_taken   = 1'b1;
        bp.upd_ghist   = 8'hA5;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (bp.pred_ghist !== 8'h4B) begin n_fail++; $display("FAIL restore_gh got %h expected 4b", bp.pred_ghist); end
    endtask

    task automatic test_same_cycle_bypass();
        logic exp_fwd;
`ifdef BP_BYPASS_EN
        exp_fwd = 1'b1;
`else
        exp_fwd = 1'b0;
`endif
        idle_inputs();
        reset_and_init();
        bp.pred_pc   = 32'hC0;
        bp.upd_valid = 1'b1;
        bp.upd_idx   = 8'h30;
        bp.upd_taken = 1'b1;
        #1;
        n_checks++;
        if (bp.pred_taken !== exp_fwd) begin n_fail++; $display("FAIL bypass got %b expected %b", bp.pred_taken, exp_fwd); end
        tick();
        bp.upd_valid = 1'b0;
        #1;
        n_checks++;
        if (bp.pred_taken !== 1'b1) begin n_fail++; $display("FAIL post_update got %b expected 1", bp.pred_taken); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_reset_mid_sweep();
        test_init_ignores();
        test_counter_saturation();
        test_spec_history();
        test_mispredict_restore();
        test_same_cycle_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
